// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 32-bit word memory responder with fixed wait states
// Three-state handshake FSM (IDLE/WAIT/ACK) over a 2^ADDR_W x 32 storage array.
module mem_responder #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t            state;
  state_t            next_state;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_write;
  logic [31:0]       lat_wdata;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       storage [0:DEPTH-1];

  logic              accept;
  logic              clash;
  logic              rd_op;
  logic [ADDR_W-1:0] rd_addr;

  assign accept = (state == S_IDLE) && (mem_read ^ mem_write);
  assign clash  = (state == S_IDLE) && mem_read && mem_write;

  // With zero wait states ACK follows acceptance directly, so the read
  // address must come from the live port rather than the latch.
  assign rd_op   = accept ? mem_read : ~lat_write;
  assign rd_addr = accept ? mem_addr : lat_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = (WS == 3'd0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt <= 3'd1) begin
          next_state = S_ACK;
        end
      end
      S_ACK:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    mem_ready = (state == S_ACK);
    err       = err_q;
    mem_rdata = rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 3'd0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      err_q <= clash;
      if (accept) begin
        lat_addr  <= mem_addr;
        lat_write <= mem_write;
        lat_wdata <= mem_wdata;
        cnt       <= WS;
      end else if (state == S_WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (next_state == S_ACK && state != S_ACK && rd_op) begin
        rdata_q <= storage[rd_addr];
      end
    end
  end

  // Storage survives reset; a write lands only on the edge leaving ACK.
  always_ff @(posedge clk) begin
    if (state == S_ACK && lat_write) begin
      storage[lat_addr] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  mem_addr;
  logic        mem_read, mem_write;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready, busy, err;

  logic [8:0]  a0;
  logic        r0, w0;
  logic [31:0] d0, rdata0;
  logic        rdy0, busy0, err0;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [0:511];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(WS), .ADDR_W(9)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  mem_responder #(.WAIT_STATES(0), .ADDR_W(9)) dut0 (
    .clk(clk), .reset(reset), .mem_addr(a0), .mem_read(r0),
    .mem_write(w0), .mem_wdata(d0), .mem_rdata(rdata0),
    .mem_ready(rdy0), .busy(busy0), .err(err0)
  );

  // Called at a negedge; mode 0 drops strobe after accept, 1 holds it to ACK,
  // 2 retargets to addr 7 with a write strobe while busy.
  task automatic access(input bit wr, input logic [8:0] a, input logic [31:0] d, input int mode);
    int ready_at = 0;
    int busy_cnt = 0;
    logic [31:0] rd_before;
    logic [31:0] exp;
    mem_addr = a; mem_wdata = d; mem_read = !wr; mem_write = wr;
    if (!wr) exp_q.push_back(model[a]);
    else model[a] = d;
    rd_before = mem_rdata;
    for (int c = 1; c <= 20 && ready_at == 0; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (mem_ready) ready_at = c;
      if (c == 1 && mode == 0) begin mem_read = 0; mem_write = 0; end
      if (c == 1 && mode == 2) begin mem_addr = 9'd7; mem_write = 1; mem_wdata = 32'hDEAD_BEEF; end
      if (mem_ready) begin mem_read = 0; mem_write = 0; end
    end
    checks++;
    if (ready_at !== WS + 1) begin
      errors++; $display("FAIL latency addr=%0d: got %0d want %0d", a, ready_at, WS + 1);
    end
    checks++;
    if (busy_cnt !== WS + 1) begin
      errors++; $display("FAIL busy_cycles addr=%0d: got %0d want %0d", a, busy_cnt, WS + 1);
    end
    checks++;
    if (!wr) begin
      exp = exp_q.pop_front();
      if (mem_rdata !== exp) begin
        errors++; $display("FAIL read_data addr=%0d: got %h want %h", a, mem_rdata, exp);
      end
    end else if (mem_rdata !== rd_before) begin
      errors++; $display("FAIL write_rdata_hold addr=%0d: got %h want %h", a, mem_rdata, rd_before);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_ready !== 1'b0) begin
      errors++; $display("FAIL extra_accept addr=%0d: busy=%b ready=%b want 0 0", a, busy, mem_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1; mem_addr = 0; mem_read = 0; mem_write = 0; mem_wdata = 0;
    a0 = 0; r0 = 0; w0 = 0; d0 = 0;
    #1 reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, mem_ready, err, busy0, rdy0, err0} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {busy, mem_ready, err, busy0, rdy0, err0});
    end
    checks++;
    if (mem_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 00000000", mem_rdata);
    end
    reset = 1;
  endtask

  task automatic test_basic();
    access(1, 9'd5, 32'h4A92_0000, 0);
    access(0, 9'd5, 32'h0, 0);
  endtask

  task automatic test_wait0();
    logic [31:0] exp;
    w0 = 1; a0 = 9'd2; d0 = 32'd91;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL ws0_write_ack: ready=%b busy=%b want 1 1", rdy0, busy0);
    end
    w0 = 0;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL ws0_idle: ready=%b busy=%b want 0 0", rdy0, busy0);
    end
    r0 = 1; exp_q.push_back(32'd91);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (rdy0 !== 1'b1 || rdata0 !== exp) begin
      errors++; $display("FAIL ws0_read: ready=%b data=%h want 1 %h", rdy0, rdata0, exp);
    end
    r0 = 0;
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    access(1, 9'd7, 32'h0000_0777, 0);
    access(0, 9'd5, 32'h0, 2);
    access(0, 9'd7, 32'h0, 0);
  endtask

  task automatic test_err();
    mem_read = 1; mem_write = 1; mem_addr = 9'd5; mem_wdata = 32'h1111_1111;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || mem_ready !== 1'b0) begin
      errors++; $display("FAIL err_pulse: err=%b busy=%b ready=%b want 1 0 0", err, busy, mem_ready);
    end
    mem_read = 0; mem_write = 0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_width: got %b want 0", err);
    end
    access(0, 9'd5, 32'h0, 0);
  endtask

  task automatic test_reset_abort();
    access(1, 9'd511, 32'h1234_5678, 0);
    mem_write = 1; mem_addr = 9'd511; mem_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_in_wait: busy got %b want 1", busy);
    end
    mem_write = 0;
    reset = 0;
    #1;
    checks++;
    if ({busy, mem_ready, err} !== 3'b0 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL abort_reset_outputs: flags=%b data=%h want 000 00000000", {busy, mem_ready, err}, mem_rdata);
    end
    @(negedge clk);
    reset = 1;
    access(0, 9'd511, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    access(1, 9'd0, 32'hA5A5_0000, 0);
    access(0, 9'd0, 32'h0, 1);
    access(0, 9'd511, 32'h0, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait0();
    test_ignore_busy();
    test_err();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
